// File: rtl/radar_state_collector.sv
// Collects individually tagged radar samples into STATE_DIM-element observation vectors
// and hands each complete vector to the policy wrapper over a valid/ready port.
module radar_state_collector #(
    parameter int STATE_DIM      = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int IDX_W          = $clog2(STATE_DIM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [IDX_W-1:0]      in_idx,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  state_valid,
    output logic [DATA_WIDTH-1:0] state_data [STATE_DIM],
    input  logic                  state_ready,
    output logic [15:0]           state_seq,
    output logic [15:0]           stat_frames,
    output logic [15:0]           stat_timeouts,
    output logic [15:0]           stat_dups,
    output logic [15:0]           stat_bad_idx
);
    localparam int                   CNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]     CNT_LIM   = CNT_W'(TIMEOUT_CYCLES);
    localparam int                   IW1       = IDX_W + 1;
    localparam logic [IDX_W:0]       DIM       = IW1'(STATE_DIM);
    localparam logic [STATE_DIM-1:0] MASK_FULL = '1;

    logic [DATA_WIDTH-1:0] shadow_q   [STATE_DIM];
    logic [DATA_WIDTH-1:0] shadow_d   [STATE_DIM];
    logic [DATA_WIDTH-1:0] out_data_q [STATE_DIM];
    logic [DATA_WIDTH-1:0] out_data_d [STATE_DIM];
    logic [STATE_DIM-1:0]  mask_q, mask_d, idx_bit, base_mask;
    logic                  parked_q, parked_d;
    logic                  valid_q, valid_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [15:0]           seq_q, seq_d, fcnt_q, fcnt_d;
    logic [15:0]           frames_q, frames_d, timeouts_q, timeouts_d;
    logic [15:0]           dups_q, dups_d, bad_q, bad_d;
    logic                  accept, good, complete, transfer, out_free;
    logic                  timeout_hit, timeout_drop, load_out, dup;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    always_comb begin
        accept   = in_valid && !parked_q;
        good     = accept && ({1'b0, in_idx} < DIM);
        idx_bit  = '0;
        if (good) idx_bit[in_idx] = 1'b1;
        transfer = valid_q && state_ready;
        out_free = !valid_q || state_ready;
        complete = good && ((mask_q | idx_bit) == MASK_FULL);
        // A sample that completes the frame on the timeout cycle beats the timeout.
        timeout_hit  = (TIMEOUT_CYCLES > 0) && !parked_q && (mask_q != '0) && (cnt_q == CNT_LIM);
        timeout_drop = timeout_hit && !complete;
        base_mask    = timeout_drop ? '0 : mask_q;
        dup          = good && !timeout_drop && ((mask_q & idx_bit) != '0);
        load_out     = (parked_q && transfer) || (complete && out_free);

        shadow_d = shadow_q;
        if (good) shadow_d[in_idx] = in_data;

        mask_d = base_mask | idx_bit;
        if (load_out) mask_d = '0;

        parked_d = parked_q;
        if (parked_q && transfer)
            parked_d = 1'b0;
        else if (complete && !out_free)
            parked_d = 1'b1;

        cnt_d = '0;
        if ((TIMEOUT_CYCLES > 0) && (mask_d != '0) && (mask_d != MASK_FULL))
            cnt_d = (base_mask == '0) ? '0 : cnt_q + CNT_W'(1);

        out_data_d = out_data_q;
        seq_d      = seq_q;
        fcnt_d     = fcnt_q;
        valid_d    = valid_q;
        if (load_out) begin
            out_data_d = shadow_d;
            seq_d      = fcnt_q;
            fcnt_d     = fcnt_q + 16'd1;
            valid_d    = 1'b1;
        end else if (transfer) begin
            valid_d = 1'b0;
        end

        frames_d   = frames_q + {15'd0, transfer};
        timeouts_d = sat_inc(timeouts_q, timeout_drop);
        dups_d     = sat_inc(dups_q, dup);
        bad_d      = sat_inc(bad_q, accept && !good);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q   <= '{default: '0};
            out_data_q <= '{default: '0};
            mask_q     <= '0;
            parked_q   <= 1'b0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
            seq_q      <= '0;
            fcnt_q     <= '0;
            frames_q   <= '0;
            timeouts_q <= '0;
            dups_q     <= '0;
            bad_q      <= '0;
        end else begin
            shadow_q   <= shadow_d;
            out_data_q <= out_data_d;
            mask_q     <= mask_d;
            parked_q   <= parked_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            seq_q      <= seq_d;
            fcnt_q     <= fcnt_d;
            frames_q   <= frames_d;
            timeouts_q <= timeouts_d;
            dups_q     <= dups_d;
            bad_q      <= bad_d;
        end
    end

    assign in_ready      = !parked_q;
    assign state_valid   = valid_q;
    assign state_data    = out_data_q;
    assign state_seq     = seq_q;
    assign stat_frames   = frames_q;
    assign stat_timeouts = timeouts_q;
    assign stat_dups     = dups_q;
    assign stat_bad_idx  = bad_q;
endmodule
